// File: rtl/c_reg_pipe_v5_0.sv
// Multi-stage valid/ready register pipeline with bubble collapsing, synchronous
// clear/set/init flush and asynchronous initialise to a parameter value.
module c_reg_pipe_v5_0 #(
  parameter int              C_WIDTH         = 16,
  parameter int              C_DEPTH         = 3,
  parameter logic [2047:0]   C_AINIT_VAL     = "",
  parameter logic [2047:0]   C_SINIT_VAL     = "",
  parameter int              C_HAS_CE        = 0,
  parameter int              C_HAS_SCLR      = 0,
  parameter int              C_HAS_SSET      = 0,
  parameter int              C_HAS_SINIT     = 0,
  parameter int              C_SYNC_ENABLE   = 0,
  parameter int              C_SYNC_PRIORITY = 1
) (
  input  logic                             clk,
  input  logic                             aclr_n,
  input  logic                             ce,
  input  logic                             sclr,
  input  logic                             sset,
  input  logic                             sinit,
  input  logic [C_WIDTH-1:0]               d,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [C_WIDTH-1:0]               q,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(C_DEPTH+1)-1:0]     occupancy
);

  localparam int OW = $clog2(C_DEPTH + 1);

  // Init strings are MSB-first ASCII; byte k from the right end is bit k.
  function automatic logic str_ok(input logic [2047:0] s);
    str_ok = 1'b1;
    for (int k = 0; k < 256; k++)
      if (!(s[8*k +: 8] inside {8'h00, 8'h30, 8'h31})) str_ok = 1'b0;
  endfunction

  function automatic logic [C_WIDTH-1:0] str_bits(input logic [2047:0] s);
    str_bits = '0;
    for (int k = 0; k < C_WIDTH; k++)
      str_bits[k] = (s[8*k +: 8] == 8'h31);
  endfunction

  if (!(str_ok(C_AINIT_VAL) && str_ok(C_SINIT_VAL))) begin : g_bad_init
    $fatal(1, "c_reg_pipe_v5_0: init value strings may contain only '0' and '1'");
  end

  localparam logic [C_WIDTH-1:0] AINIT = str_bits(C_AINIT_VAL);
  localparam logic [C_WIDTH-1:0] SINIT = str_bits(C_SINIT_VAL);

  logic [C_WIDTH-1:0] data_r [C_DEPTH];
  logic [C_DEPTH-1:0] vld_r;
  logic [OW-1:0]      occ_r;
  logic               run_r;

  logic               ce_eff, sclr_e, sset_e, sinit_e, sync_act, advance;
  logic [C_WIDTH-1:0] flush_val;
  logic [C_DEPTH:0]   rdy;
  logic [C_DEPTH:0]   chain_v;
  logic [C_WIDTH-1:0] chain_d [C_DEPTH+1];
  logic [C_DEPTH-1:0] vld_nxt;
  logic [OW-1:0]      occ_nxt;

  assign ce_eff   = (C_HAS_CE != 0) ? ce : 1'b1;
  assign sclr_e   = (C_HAS_SCLR != 0) & sclr;
  assign sset_e   = (C_HAS_SSET != 0) & sset;
  assign sinit_e  = (C_HAS_SINIT != 0) & sinit;
  assign sync_act = (ce_eff | (C_SYNC_ENABLE == 0)) & (sclr_e | sset_e | sinit_e);
  // run_r keeps the input closed until the first edge after reset release
  assign advance  = ce_eff & run_r & ~sync_act;

  always_comb begin
    flush_val = SINIT;
    if (sclr_e && sset_e)
      flush_val = (C_SYNC_PRIORITY != 0) ? '0 : '1;
    else if (sclr_e)
      flush_val = '0;
    else if (sset_e)
      flush_val = '1;
  end

  always_comb begin
    rdy = '0;
    rdy[C_DEPTH] = out_ready;
    for (int i = C_DEPTH - 1; i >= 0; i--)
      rdy[i] = ~vld_r[i] | rdy[i+1];
  end

  always_comb begin
    chain_v    = {vld_r, in_valid};
    chain_d[0] = d;
    for (int i = 0; i < C_DEPTH; i++)
      chain_d[i+1] = data_r[i];
  end

  always_comb begin
    vld_nxt = vld_r;
    if (sync_act)
      vld_nxt = '0;
    else if (advance)
      for (int i = 0; i < C_DEPTH; i++)
        if (rdy[i]) vld_nxt[i] = chain_v[i];
    occ_nxt = OW'($countones(vld_nxt));
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < C_DEPTH; i++) data_r[i] <= AINIT;
      vld_r <= '0;
      occ_r <= '0;
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      vld_r <= vld_nxt;
      occ_r <= occ_nxt;
      // Stages only capture valid words so Q stays stable across bubbles
      for (int i = 0; i < C_DEPTH; i++) begin
        if (sync_act)
          data_r[i] <= flush_val;
        else if (advance && rdy[i] && chain_v[i])
          data_r[i] <= chain_d[i];
      end
    end
  end

  assign in_ready  = advance & rdy[0];
  assign q         = data_r[C_DEPTH-1];
  assign out_valid = vld_r[C_DEPTH-1];
  assign occupancy = occ_r;

endmodule
